// File: rtl/kong_pkg.sv
// Shared Kong sequencer constants and the sequencer state encoding.
package kong_pkg;

  localparam int KONG_NUM_BARRELS   = 4;
  localparam int KONG_XMIN          = 64;
  localparam int KONG_XMAX          = 576;
  localparam int KONG_THROW_STEPS   = 96;
  localparam int KONG_SETTLE_CYCLES = 2_100_000;
  localparam int KONG_THROW_CYCLES  = 4_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WALK      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_SLOT = 3'd3,
    ST_THROW     = 3'd4
  } kong_seq_state_t;

endpackage

// File: rtl/barrel_slot_picker.sv
// Lowest-index free barrel slot finder; purely combinational.
module barrel_slot_picker #(
  parameter int NUM_BARRELS = 4
) (
  input  logic [NUM_BARRELS-1:0]         i_busy,
  output logic [$clog2(NUM_BARRELS)-1:0] o_id,
  output logic                           o_any_free
);

  localparam int ID_W = $clog2(NUM_BARRELS);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    o_id       = {ID_W{1'b0}};
    o_any_free = ~&i_busy;
    for (int i = NUM_BARRELS - 1; i >= 0; i--) begin
      o_id = i_busy[i] ? o_id : ID_W'(i);
    end
  end

endmodule

// File: rtl/kong_sequencer.sv
// Autonomous Kong controller: patrols between x bounds, pauses, throws a
// barrel into the lowest free slot, then resumes the patrol.
module kong_sequencer
  import kong_pkg::*;
#(
  parameter int NUM_BARRELS   = KONG_NUM_BARRELS,
  parameter int XMIN          = KONG_XMIN,
  parameter int XMAX          = KONG_XMAX,
  parameter int THROW_STEPS   = KONG_THROW_STEPS,
  parameter int SETTLE_CYCLES = KONG_SETTLE_CYCLES,
  parameter int THROW_CYCLES  = KONG_THROW_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_game,
  input  logic                           game_over,
  input  logic [10:0]                    kong_xpos,
  input  logic [NUM_BARRELS-1:0]         barrel_busy,
  output logic                           left,
  output logic                           right,
  output logic                           animation,
  output logic                           spawn_valid,
  output logic [$clog2(NUM_BARRELS)-1:0] spawn_id,
  output logic [10:0]                    spawn_xpos,
  output logic                           spawn_dir
);

  localparam int          ID_W       = $clog2(NUM_BARRELS);
  localparam logic [10:0] XMIN_V     = 11'(XMIN);
  localparam logic [10:0] XMAX_V     = 11'(XMAX);
  localparam logic [9:0]  STEPS_V    = 10'(THROW_STEPS);
  localparam logic [22:0] SETTLE_END = 23'(SETTLE_CYCLES - 1);
  localparam logic [22:0] THROW_END  = 23'(THROW_CYCLES - 1);

  kong_seq_state_t r_state, w_state_nxt;
  logic            r_dir, w_dir_nxt;
  logic [9:0]      r_step_cnt, w_step_cnt_nxt, w_step_cnt_inc;
  logic [22:0]     r_timer, w_timer_nxt;
  logic [10:0]     r_xpos_q;
  logic            r_left, r_right, r_anim, r_spawn_valid;
  logic [ID_W-1:0] r_spawn_id;
  logic [10:0]     r_spawn_xpos;
  logic            r_spawn_dir;
  logic            w_left_nxt, w_right_nxt, w_anim_nxt, w_spawn_nxt;
  logic            w_active, w_step, w_rev, w_any_free;
  logic [ID_W-1:0] w_free_id;

  barrel_slot_picker #(.NUM_BARRELS(NUM_BARRELS)) u_picker (
    .i_busy     (barrel_busy),
    .o_id       (w_free_id),
    .o_any_free (w_any_free)
  );

  assign w_active       = start_game & ~game_over;
  assign w_step         = (kong_xpos != r_xpos_q);
  assign w_rev          = (~r_dir & (kong_xpos <= XMIN_V)) | (r_dir & (kong_xpos >= XMAX_V));
  assign w_step_cnt_inc = (r_step_cnt == STEPS_V) ? r_step_cnt : r_step_cnt + {9'd0, w_step};

  // Outputs are computed for the next state so they register alongside it.
  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_step_cnt_nxt = r_step_cnt;
    w_timer_nxt    = r_timer;
    w_left_nxt     = 1'b0;
    w_right_nxt    = 1'b0;
    w_anim_nxt     = 1'b0;
    w_spawn_nxt    = 1'b0;
    if (!w_active) begin
      w_state_nxt    = ST_IDLE;
      w_step_cnt_nxt = 10'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt    = ST_WALK;
          w_step_cnt_nxt = 10'd0;
        end
        ST_WALK: begin
          w_dir_nxt      = r_dir ^ w_rev;
          w_step_cnt_nxt = w_step_cnt_inc;
          if (w_step_cnt_inc == STEPS_V) begin
            w_state_nxt = ST_SETTLE;
            w_timer_nxt = 23'd0;
          end else begin
            w_left_nxt  = ~w_dir_nxt;
            w_right_nxt = w_dir_nxt;
          end
        end
        ST_SETTLE: begin
          if (r_timer == SETTLE_END) begin
            w_timer_nxt = 23'd0;
            if (w_any_free) begin
              w_state_nxt = ST_THROW;
              w_anim_nxt  = 1'b1;
              w_spawn_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WAIT_SLOT;
            end
          end else begin
            w_timer_nxt = r_timer + 23'd1;
          end
        end
        ST_WAIT_SLOT: begin
          if (w_any_free) begin
            w_state_nxt = ST_THROW;
            w_timer_nxt = 23'd0;
            w_anim_nxt  = 1'b1;
            w_spawn_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_SLOT;
          end
        end
        ST_THROW: begin
          if (r_timer == THROW_END) begin
            w_state_nxt    = ST_WALK;
            w_timer_nxt    = 23'd0;
            w_step_cnt_nxt = 10'd0;
            w_left_nxt     = ~r_dir;
            w_right_nxt    = r_dir;
          end else begin
            w_timer_nxt = r_timer + 23'd1;
            w_anim_nxt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Spawn fields are captured only on the cycle that enters the throw.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir         <= 1'b1;
      r_step_cnt    <= 10'd0;
      r_timer       <= 23'd0;
      r_xpos_q      <= kong_xpos;
      r_left        <= 1'b0;
      r_right       <= 1'b0;
      r_anim        <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_id    <= {ID_W{1'b0}};
      r_spawn_xpos  <= 11'd0;
      r_spawn_dir   <= 1'b0;
    end else begin
      r_dir         <= w_dir_nxt;
      r_step_cnt    <= w_step_cnt_nxt;
      r_timer       <= w_timer_nxt;
      r_xpos_q      <= kong_xpos;
      r_left        <= w_left_nxt;
      r_right       <= w_right_nxt;
      r_anim        <= w_anim_nxt;
      r_spawn_valid <= w_spawn_nxt;
      if (w_spawn_nxt) begin
        r_spawn_id   <= w_free_id;
        r_spawn_xpos <= kong_xpos;
        r_spawn_dir  <= r_dir;
      end
    end
  end

  assign left        = r_left;
  assign right       = r_right;
  assign animation   = r_anim;
  assign spawn_valid = r_spawn_valid;
  assign spawn_id    = r_spawn_id;
  assign spawn_xpos  = r_spawn_xpos;
  assign spawn_dir   = r_spawn_dir;

endmodule

// File: tb/tb_kong_sequencer.sv
// Scoreboard bench for kong_sequencer driven by a 2-cycles-per-pixel movement model.
module tb_kong_sequencer;

  typedef struct packed {
    logic [1:0]  id;
    logic [10:0] x;
    logic        dir;
  } spawn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_game = 1'b1;
  logic        game_over = 1'b0;
  logic [10:0] xpos = 11'd12;
  logic [3:0]  barrel_busy = 4'b0101;
  logic        left, right, animation, spawn_valid, spawn_dir;
  logic [1:0]  spawn_id;
  logic [10:0] spawn_xpos;
  logic        pcnt = 1'b0;

  int     checks = 0;
  int     failures = 0;
  spawn_t exp_q[$];
  bit     chk_anim = 1'b1;

  kong_sequencer #(
    .NUM_BARRELS(4), .XMIN(10), .XMAX(20), .THROW_STEPS(4),
    .SETTLE_CYCLES(3), .THROW_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .game_over(game_over),
    .kong_xpos(xpos), .barrel_busy(barrel_busy), .left(left), .right(right),
    .animation(animation), .spawn_valid(spawn_valid), .spawn_id(spawn_id),
    .spawn_xpos(spawn_xpos), .spawn_dir(spawn_dir)
  );

  always #5 clk = ~clk;

  // Movement model: one pixel per two cycles of a single held command, frozen by animation.
  always @(posedge clk) begin
    if (rst || animation || (left == right)) begin
      pcnt <= 1'b0;
    end else if (pcnt) begin
      pcnt <= 1'b0;
      xpos <= right ? xpos + 11'd1 : xpos - 11'd1;
    end else begin
      pcnt <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0: pick = right;
      1: pick = left;
      2: pick = animation;
      3: pick = spawn_valid;
      default: pick = 1'bx;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
    int n = 0;
    forever begin
      if (pick(sel) === val) break;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL timeout_%s: got %b expected %b within %0d cycles", name, pick(sel), val, budget);
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Scoreboard monitor for spawn transactions.
  initial forever begin
    spawn_t e;
    @(negedge clk);
    if (!rst && spawn_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_spawn: got id=%0d x=%0d dir=%0d expected no spawn", spawn_id, spawn_xpos, spawn_dir);
      end else begin
        e = exp_q.pop_front();
        chk("spawn_id", 32'(spawn_id), 32'(e.id));
        chk("spawn_xpos", 32'(spawn_xpos), 32'(e.x));
        chk("spawn_dir", 32'(spawn_dir), 32'(e.dir));
      end
    end
  end

  // Animation length monitor.
  initial begin
    int anim_len = 0;
    forever begin
      @(negedge clk);
      if (animation) begin
        anim_len++;
      end else if (anim_len != 0) begin
        if (chk_anim) chk("anim_len", 32'(anim_len), 32'd5);
        anim_len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    repeat (3) @(negedge clk);
    chk("rst_left", 32'(left), 32'd0);
    chk("rst_right", 32'(right), 32'd0);
    chk("rst_anim", 32'(animation), 32'd0);
    chk("rst_spawn", {28'd0, spawn_valid, spawn_id, spawn_dir}, 32'd0);
    chk("rst_spawn_x", 32'(spawn_xpos), 32'd0);

    // Throw 1: 12 -> 16 walking right, slot 1 is the lowest free one.
    exp_q.push_back('{id: 2'd1, x: 11'd16, dir: 1'b1});
    rst = 1'b0;
    @(negedge clk);
    chk("right_after_1", 32'(right), 32'd0);
    @(negedge clk);
    chk("right_after_2", {30'd0, left, right}, 32'b01);
    wait_sig("settle1", 0, 1'b0, 100);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (spawn_valid || left || right) break;
      n++;
      @(negedge clk);
    end
    chk("settle_len", 32'(n), 32'd3);
    chk("spawn_after_settle", 32'(spawn_valid), 32'd1);
    wait_sig("anim1_end", 2, 1'b0, 20);
    chk("resume_right", {30'd0, left, right}, 32'b01);

    // Throw 2: 4th step lands on XMAX, reversal and throw together.
    exp_q.push_back('{id: 2'd1, x: 11'd20, dir: 1'b0});
    wait_sig("spawn2", 3, 1'b1, 100);
    wait_sig("anim2_end", 2, 1'b0, 20);
    chk("resume_left", {30'd0, left, right}, 32'b10);

    // Throw 3: every slot busy at settle end, released later.
    barrel_busy = 4'b1111;
    wait_sig("settle3", 1, 1'b0, 100);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= spawn_valid | left | right | animation;
    end
    chk("wait_slot_quiet", 32'(seen), 32'd0);
    exp_q.push_back('{id: 2'd2, x: 11'd16, dir: 1'b0});
    barrel_busy = 4'b1011;
    @(negedge clk);
    chk("spawn_after_free", 32'(spawn_valid), 32'd1);
    wait_sig("anim3_end", 2, 1'b0, 20);

    // Throw 4 at x=12, then reversal at XMIN without a gap cycle.
    exp_q.push_back('{id: 2'd2, x: 11'd12, dir: 1'b0});
    wait_sig("spawn4", 3, 1'b1, 100);
    wait_sig("anim4_end", 2, 1'b0, 20);
    chk("resume_left4", {30'd0, left, right}, 32'b10);
    wait_sig("rev_min", 1, 1'b0, 100);
    chk("rev_min_right", 32'(right), 32'd1);

    // Throw 5 at x=12 heading right, aborted by game_over.
    exp_q.push_back('{id: 2'd2, x: 11'd12, dir: 1'b1});
    wait_sig("spawn5", 3, 1'b1, 100);
    @(negedge clk);
    chk_anim = 1'b0;
    game_over = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {28'd0, animation, spawn_valid, left, right}, 32'd0);
    game_over = 1'b0;
    start_game = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outputs", {28'd0, animation, spawn_valid, left, right}, 32'd0);
    start_game = 1'b1;
    @(negedge clk);
    chk("restart_1", {30'd0, left, right}, 32'b00);
    @(negedge clk);
    chk("restart_dir", {30'd0, left, right}, 32'b01);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
